pn_dac_sched: RTL and testbench

Sample scheduler and source arbiter in front of the 1-bit sigma-delta DAC. Accepts signed samples from two producers over valid/ready handshakes: A (demodulated audio) and B (tone/beep generator). Once every DIV clocks (8 kHz at 16.384 MHz) it selects, mixes or mutes them and presents a held two's-complement word on the DAC data input. It also handles underrun, enable sequencing and underrun statistics.

---
 rtl/pn_dac_sched.sv | 181 ++++++++++++++++++
 tb/tb_pn_dac_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pn_dac_sched.sv
// rtl/pn_dac_sched.sv - DAC sample scheduler / A-B source arbiter with underrun stats.
// Optional PN_DAC_FADE_EN: underrun ticks decay DACin by >>>1 instead of holding it.
module pn_dac_sched #(
   parameter int MSBI = 16,
   parameter int DIV  = 2048
) (
   input  logic            Clk,
   input  logic            nRst,
   input  logic            En,
   input  logic [1:0]      Sel,
   input  logic [MSBI-1:0] ADat,
   input  logic            AVld,
   output logic            ARdy,
   input  logic [MSBI-1:0] BDat,
   input  logic            BVld,
   output logic            BRdy,
   output logic [MSBI-1:0] DACin,
   output logic            SmpStb,
   output logic            Underrun,
   output logic [7:0]      UnderCnt
);
   localparam int CW = $clog2(DIV);

   typedef enum logic [1:0] {MUTE, SYNC, RUN} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            tick;
   logic [MSBI-1:0] a_reg, a_reg_nx, b_reg, b_reg_nx;
   logic            a_full, a_full_nx, b_full, b_full_nx;
   logic [MSBI-1:0] dac_nx, mix, hold;
   logic [MSBI:0]   sum;
   logic            a_rdy_nx, b_rdy_nx, stb_nx, und_nx;
   logic [7:0]      ucnt_nx;

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         state    <= MUTE;
         cnt      <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         a_full   <= 1'b0;
         b_full   <= 1'b0;
         ARdy     <= 1'b0;
         BRdy     <= 1'b0;
         DACin    <= '0;
         SmpStb   <= 1'b0;
         Underrun <= 1'b0;
         UnderCnt <= '0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         a_reg    <= a_reg_nx;
         b_reg    <= b_reg_nx;
         a_full   <= a_full_nx;
         b_full   <= b_full_nx;
         ARdy     <= a_rdy_nx;
         BRdy     <= b_rdy_nx;
         DACin    <= dac_nx;
         SmpStb   <= stb_nx;
         Underrun <= und_nx;
         UnderCnt <= ucnt_nx;
      end
   end

   always_comb begin
      tick   = (cnt == CW'(DIV - 1));
      cnt_nx = tick ? '0 : cnt + CW'(1);

      // Mix in MSBI+1 bits; a sign mismatch of the top two bits means overflow.
      sum = {a_reg[MSBI-1], a_reg} + {b_reg[MSBI-1], b_reg};
      if (sum[MSBI] != sum[MSBI-1])
         mix = sum[MSBI] ? {1'b1, {(MSBI-1){1'b0}}} : {1'b0, {(MSBI-1){1'b1}}};
      else
         mix = sum[MSBI-1:0];

`ifdef PN_DAC_FADE_EN
      hold = MSBI'($signed(DACin) >>> 1);
`else
      hold = DACin;
`endif

      state_nx  = state;
      a_reg_nx  = a_reg;
      b_reg_nx  = b_reg;
      a_full_nx = a_full;
      b_full_nx = b_full;
      dac_nx    = DACin;
      stb_nx    = 1'b0;
      und_nx    = 1'b0;

      case (state)
         MUTE: begin
            a_full_nx = 1'b0;
            b_full_nx = 1'b0;
            dac_nx    = '0;
            if (En) state_nx = SYNC;
         end
         SYNC: begin
            dac_nx = '0;
            if (!En) begin
               state_nx  = MUTE;
               a_full_nx = 1'b0;
               b_full_nx = 1'b0;
            end else if (tick) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            if (!En) begin
               state_nx  = MUTE;
               a_full_nx = 1'b0;
               b_full_nx = 1'b0;
               dac_nx    = '0;
            end else if (tick) begin
               stb_nx = 1'b1;
               case (Sel)
                  2'b00: begin
                     dac_nx    = '0;
                     a_full_nx = 1'b0;
                     b_full_nx = 1'b0;
                  end
                  2'b01: begin
                     b_full_nx = 1'b0;
                     if (a_full) begin
                        dac_nx    = a_reg;
                        a_full_nx = 1'b0;
                     end else begin
                        dac_nx = hold;
                        und_nx = 1'b1;
                     end
                  end
                  2'b10: begin
                     a_full_nx = 1'b0;
                     if (b_full) begin
                        dac_nx    = b_reg;
                        b_full_nx = 1'b0;
                     end else begin
                        dac_nx = hold;
                        und_nx = 1'b1;
                     end
                  end
                  default: begin
                     if (a_full && b_full) begin
                        dac_nx    = mix;
                        a_full_nx = 1'b0;
                        b_full_nx = 1'b0;
                     end else begin
                        dac_nx = hold;
                        und_nx = 1'b1;
                     end
                  end
               endcase
            end
         end
         default: state_nx = MUTE;
      endcase

      // Loads land after tick processing, so a tick-cycle arrival is kept for the next tick.
      if (state_nx != MUTE) begin
         if (AVld && ARdy) begin
            a_reg_nx  = ADat;
            a_full_nx = 1'b1;
         end
         if (BVld && BRdy) begin
            b_reg_nx  = BDat;
            b_full_nx = 1'b1;
         end
      end

      a_rdy_nx = !a_full_nx && (state_nx != MUTE);
      b_rdy_nx = !b_full_nx && (state_nx != MUTE);

      if (!En)
         ucnt_nx = '0;
      else if (und_nx && (UnderCnt != 8'hFF))
         ucnt_nx = UnderCnt + 8'd1;
      else
         ucnt_nx = UnderCnt;
   end
endmodule

// File: tb/tb_pn_dac_sched.sv
// tb/tb_pn_dac_sched.sv - directed bench for pn_dac_sched with a queue-based reference model.
module tb_pn_dac_sched;
   localparam int MSBI = 16;
   localparam int DIV  = 8;

   logic        Clk = 1'b0;
   logic        nRst = 1'b0;
   logic        En = 1'b0;
   logic [1:0]  Sel = 2'b00;
   logic [15:0] ADat = '0;
   logic [15:0] BDat = '0;
   logic        AVld = 1'b0;
   logic        BVld = 1'b0;
   logic        ARdy, BRdy, SmpStb, Underrun;
   logic [15:0] DACin;
   logic [7:0]  UnderCnt;

   int checks = 0;
   int errors = 0;
   int edges  = 0;

   always #5 Clk = ~Clk;

   pn_dac_sched #(.MSBI(MSBI), .DIV(DIV)) dut (
      .Clk(Clk), .nRst(nRst), .En(En), .Sel(Sel),
      .ADat(ADat), .AVld(AVld), .ARdy(ARdy),
      .BDat(BDat), .BVld(BVld), .BRdy(BRdy),
      .DACin(DACin), .SmpStb(SmpStb), .Underrun(Underrun), .UnderCnt(UnderCnt)
   );

   logic [15:0] a_q[$];
   logic [15:0] b_q[$];
   bit          m_live, m_run, m_tick, m_la, m_lb;
   int          m_cnt;
   logic        e_ardy, e_brdy, e_stb, e_und;
   logic [15:0] e_dac;
   logic [7:0]  e_ucnt;

   function automatic logic [15:0] mix_sat(input logic [15:0] a, input logic [15:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return 16'(s);
   endfunction

   function automatic logic [15:0] held(input logic [15:0] v);
      int x;
      x = int'($signed(v));
`ifdef PN_DAC_FADE_EN
      x = (x < 0) ? -((1 - x) / 2) : x / 2;
`endif
      return 16'(x);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, edges);
      end
   endtask

   task automatic wait_stb(input string name);
      int n;
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (!SmpStb && n < 40);
      if (!SmpStb) begin
         checks++;
         errors++;
         $display("FAIL %s: no SmpStb within 40 cycles", name);
      end
   endtask

   // Reference model: en/sync/run phases, one-deep queues per source.
   always @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         edges = 0; m_cnt = 0; m_live = 0; m_run = 0;
         a_q.delete(); b_q.delete();
         e_ardy = 0; e_brdy = 0; e_stb = 0; e_und = 0; e_dac = '0; e_ucnt = '0;
      end else begin
         edges++;
         m_tick = (m_cnt == DIV - 1);
         m_cnt  = m_tick ? 0 : m_cnt + 1;
         m_la   = AVld && e_ardy;
         m_lb   = BVld && e_brdy;
         e_stb  = 0;
         e_und  = 0;
         if (!En) begin
            m_live = 0; m_run = 0;
            a_q.delete(); b_q.delete();
            e_dac = '0; e_ucnt = '0;
         end else if (!m_live) begin
            m_live = 1;
         end else begin
            if (m_tick && !m_run) begin
               m_run = 1;
            end else if (m_tick) begin
               e_stb = 1;
               case (Sel)
                  2'b00: begin e_dac = '0; a_q.delete(); b_q.delete(); end
                  2'b01: begin
                     b_q.delete();
                     if (a_q.size() != 0) e_dac = a_q.pop_front();
                     else begin e_und = 1; e_dac = held(e_dac); end
                  end
                  2'b10: begin
                     a_q.delete();
                     if (b_q.size() != 0) e_dac = b_q.pop_front();
                     else begin e_und = 1; e_dac = held(e_dac); end
                  end
                  default: begin
                     if (a_q.size() != 0 && b_q.size() != 0) e_dac = mix_sat(a_q.pop_front(), b_q.pop_front());
                     else begin e_und = 1; e_dac = held(e_dac); end
                  end
               endcase
               if (e_und && e_ucnt != 8'd255) e_ucnt = e_ucnt + 8'd1;
            end
            if (m_la) a_q.push_back(ADat);
            if (m_lb) b_q.push_back(BDat);
         end
         e_ardy = m_live && (a_q.size() == 0);
         e_brdy = m_live && (b_q.size() == 0);
      end
   end

   always @(negedge Clk) begin
      if (nRst) begin
         chk("m_DACin", 32'(DACin), 32'(e_dac));
         chk("m_SmpStb", 32'(SmpStb), 32'(e_stb));
         chk("m_Underrun", 32'(Underrun), 32'(e_und));
         chk("m_UnderCnt", 32'(UnderCnt), 32'(e_ucnt));
         chk("m_ARdy", 32'(ARdy), 32'(e_ardy));
         chk("m_BRdy", 32'(BRdy), 32'(e_brdy));
      end
   end

   initial begin
      int e0, t1, n;
      logic [15:0] fade_exp;
      fade_exp = 16'h4000;
`ifdef PN_DAC_FADE_EN
      fade_exp = 16'h2000;
`endif
      repeat (3) @(negedge Clk);
      chk("rst_DACin", 32'(DACin), 32'h0);
      chk("rst_SmpStb", 32'(SmpStb), 32'h0);
      chk("rst_ARdy", 32'(ARdy), 32'h0);
      chk("rst_BRdy", 32'(BRdy), 32'h0);
      chk("rst_UnderCnt", 32'(UnderCnt), 32'h0);
      nRst = 1'b1;
      repeat (2) @(negedge Clk);

      // Enable at cycle 2: SYNC tick at edge 8 is silent, first strobe at edge 16.
      En = 1'b1; Sel = 2'b01; ADat = 16'h1234; AVld = 1'b1;
      wait_stb("en_first");
      chk("en_first_edge", 32'(edges), 32'd16);
      chk("en_dac", 32'(DACin), 32'h1234);
      repeat (2) @(negedge Clk);
      chk("en_ardy_full", 32'(ARdy), 32'h0);

      AVld = 1'b0;
      wait_stb("ur_drain");
      ADat = 16'h4000; AVld = 1'b1;
      wait_stb("ur_load");
      chk("ur_pre_dac", 32'(DACin), 32'h4000);
      AVld = 1'b0;
      wait_stb("ur_tick");
      chk("ur_pulse", 32'(Underrun), 32'h1);
      chk("ur_cnt", 32'(UnderCnt), 32'd1);
      chk("ur_dac", 32'(DACin), 32'(fade_exp));

      Sel = 2'b11; ADat = 16'h7000; BDat = 16'h2000; AVld = 1'b1; BVld = 1'b1;
      wait_stb("mix1");
      chk("mix_pos_sat", 32'(DACin), 32'h7FFF);
      ADat = 16'h9000; BDat = 16'hA000;
      wait_stb("mix2");
      chk("mix_neg_sat", 32'(DACin), 32'h8000);
      ADat = 16'h0100; BDat = 16'hFF00;
      wait_stb("mix3");
      chk("mix_zero", 32'(DACin), 32'h0000);
      ADat = 16'h0010; BVld = 1'b0;
      wait_stb("mix_ur");
      chk("mix_ur_pulse", 32'(Underrun), 32'h1);
      chk("mix_ur_cnt", 32'(UnderCnt), 32'd2);
      BDat = 16'h0020; BVld = 1'b1;
      wait_stb("mix_keep");
      chk("mix_kept_a", 32'(DACin), 32'h0030);

      // Unselected B: discarded every tick, so BRdy is high one cycle per tick.
      Sel = 2'b01; ADat = 16'h0101; BDat = 16'h5555;
      wait_stb("disc_settle");
      n = 0;
      for (int i = 0; i < 24; i++) begin
         if (BRdy) n++;
         @(negedge Clk);
      end
      chk("disc_brdy_pulses", 32'(n), 32'd3);
      chk("disc_dac", 32'(DACin), 32'h0101);

      repeat (3) @(negedge Clk);
      En = 1'b0;
      @(negedge Clk);
      chk("dis_dac", 32'(DACin), 32'h0);
      chk("dis_ardy", 32'(ARdy), 32'h0);
      chk("dis_brdy", 32'(BRdy), 32'h0);
      chk("dis_ucnt", 32'(UnderCnt), 32'h0);
      En = 1'b1;
      e0 = edges;
      t1 = ((e0 + 1) / DIV + 1) * DIV;
      wait_stb("reen");
      chk("reen_edge", 32'(edges), 32'(t1 + DIV));

      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while ((edges % DIV) != DIV - 1 && n < 20);
      En = 1'b0;
      @(negedge Clk);
      chk("tick_dis_stb", 32'(SmpStb), 32'h0);
      chk("tick_dis_dac", 32'(DACin), 32'h0);
      En = 1'b1;
      wait_stb("pre_rst");
      repeat (3) @(negedge Clk);

      #2 nRst = 1'b0;
      #1;
      chk("arst_DACin", 32'(DACin), 32'h0);
      chk("arst_SmpStb", 32'(SmpStb), 32'h0);
      chk("arst_ARdy", 32'(ARdy), 32'h0);
      chk("arst_BRdy", 32'(BRdy), 32'h0);
      chk("arst_Underrun", 32'(Underrun), 32'h0);
      chk("arst_UnderCnt", 32'(UnderCnt), 32'h0);
      @(negedge Clk);
      nRst = 1'b1;
      wait_stb("arst_reen");
      chk("arst_reen_edge", 32'(edges), 32'd16);
      chk("arst_reen_dac", 32'(DACin), 32'h0101);

      repeat (4) @(negedge Clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
